// File: rtl/aes_stream_pkg.sv
// Shared widths and FSM encoding for the AES stream adapter.
package aes_stream_pkg;
    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    localparam logic [1:0] LAST_IDX = 2'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        DRAIN   = 2'd3
    } state_e;
endpackage

// File: rtl/aes_word_serializer.sv
// Holds the captured 128-bit result and emits it as four 32-bit words, MSW first.
module aes_word_serializer
    import aes_stream_pkg::*;
(
    input  logic               AES_clk,
    input  logic               AES_rst,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic               start,
    output logic               m_word_valid,
    input  logic               m_word_ready,
    output logic [WORD_W-1:0]  m_word,
    output logic               last_hs
);

    logic [BLOCK_W-1:0] block_q, block_d;
    logic [1:0]         idx_q, idx_d;
    logic               active_q, active_d;
    logic [WORD_W-1:0]  word_sel;

    assign last_hs = active_q && m_word_ready && (idx_q == LAST_IDX);

    always_comb begin
        block_d  = block_q;
        idx_d    = idx_q;
        active_d = active_q;
        if (load) begin
            block_d = load_data;
        end
        if (active_q && m_word_ready) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == LAST_IDX) begin
                active_d = 1'b0;
            end
        end
        if (start) begin
            active_d = 1'b1;
            idx_d    = 2'd0;
        end
    end

    always_comb begin
        word_sel = '0;
        case (idx_q)
            2'd0: word_sel = block_q[127:96];
            2'd1: word_sel = block_q[95:64];
            2'd2: word_sel = block_q[63:32];
            2'd3: word_sel = block_q[31:0];
            default: word_sel = '0;
        endcase
    end

    assign m_word_valid = active_q;
    assign m_word       = active_q ? word_sel : '0;

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            block_q  <= '0;
            idx_q    <= 2'd0;
            active_q <= 1'b0;
        end else begin
            block_q  <= block_d;
            idx_q    <= idx_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/aes_stream_adapter.sv
// Word-stream shell around AES_top: packs four words, launches the core with a held
// enable window, captures the first result and streams it back out.
//
//   state   | meaning
//   COLLECT | accepting input words / key loads
//   LAUNCH  | core_en high for the enable window
//   WAIT    | core_en low, waiting for result with timeout
//   DRAIN   | emitting the four result words
module aes_stream_adapter
    import aes_stream_pkg::*;
#(
    parameter int EN_HOLD_CYCLES = 51,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               AES_clk,
    input  logic               AES_rst,
    input  logic [BLOCK_W-1:0] s_key,
    input  logic               s_key_load,
    input  logic               s_word_valid,
    output logic               s_word_ready,
    input  logic [WORD_W-1:0]  s_word,
    output logic               core_en,
    output logic [BLOCK_W-1:0] core_data,
    output logic [BLOCK_W-1:0] core_key,
    input  logic               core_out_valid,
    input  logic [BLOCK_W-1:0] core_out,
    output logic               m_word_valid,
    input  logic               m_word_ready,
    output logic [WORD_W-1:0]  m_word,
    output logic               busy,
    output logic               timeout_err
);

    localparam int HOLD_W = $clog2(EN_HOLD_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(EN_HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               done_q, done_d;
    logic               core_en_q, core_en_d;
    logic               busy_q, busy_d;
    logic               tmo_q, tmo_d;
    logic               ready_q, ready_d;
    logic               accept, capture, start, last_hs;

    // Ready is forced low combinationally so nothing is offered while reset is held.
    assign s_word_ready = ready_q && !AES_rst;
    assign accept       = s_word_ready && s_word_valid;
    assign capture      = ((state_q == LAUNCH) || (state_q == WAIT)) && core_out_valid && !done_q;
    assign start        = (state_d == DRAIN) && (state_q != DRAIN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        data_d  = data_q;
        hold_d  = hold_q;
        to_d    = to_q;
        done_d  = done_q || capture;
        tmo_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (s_key_load) begin
                    key_d = s_key;
                end
                if (accept) begin
                    data_d = {data_q[BLOCK_W-WORD_W-1:0], s_word};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = LAUNCH;
                        hold_d  = HOLD_LOAD;
                        done_d  = 1'b0;
                    end
                end
            end
            LAUNCH: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (done_q || capture) begin
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT;
                    to_d    = TO_LOAD;
                end
            end
            WAIT: begin
                if (done_q || capture) begin
                    state_d = DRAIN;
                end else if (to_q == '0) begin
                    state_d = COLLECT;
                    tmo_d   = 1'b1;
                end else begin
                    to_d = to_q - TO_W'(1);
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        core_en_d = (state_d == LAUNCH);
        busy_d    = (state_d != COLLECT);
        ready_d   = (state_d == COLLECT);
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state_q   <= COLLECT;
            cnt_q     <= 2'd0;
            key_q     <= '0;
            data_q    <= '0;
            hold_q    <= '0;
            to_q      <= '0;
            done_q    <= 1'b0;
            core_en_q <= 1'b0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            data_q    <= data_d;
            hold_q    <= hold_d;
            to_q      <= to_d;
            done_q    <= done_d;
            core_en_q <= core_en_d;
            busy_q    <= busy_d;
            tmo_q     <= tmo_d;
            ready_q   <= ready_d;
        end
    end

    assign core_en     = core_en_q;
    assign core_data   = data_q;
    assign core_key    = key_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;

    aes_word_serializer u_ser (
        .AES_clk      (AES_clk),
        .AES_rst      (AES_rst),
        .load         (capture),
        .load_data    (core_out),
        .start        (start),
        .m_word_valid (m_word_valid),
        .m_word_ready (m_word_ready),
        .m_word       (m_word),
        .last_hs      (last_hs)
    );

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Directed bench for aes_stream_adapter with a stub AES core.
module tb_aes_stream_adapter;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_F    = {128{1'b1}};
    localparam logic [127:0] GARBAGE  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    localparam int           NEVER    = 2_000_000;

    logic         AES_clk = 1'b0;
    logic         AES_rst = 1'b1;
    logic [127:0] s_key = '0;
    logic         s_key_load = 1'b0;
    logic         s_word_valid = 1'b0;
    logic         s_word_ready;
    logic [31:0]  s_word = '0;
    logic         core_en;
    logic [127:0] core_data;
    logic [127:0] core_key;
    logic         core_out_valid;
    logic [127:0] core_out;
    logic         m_word_valid;
    logic         m_word_ready = 1'b0;
    logic [31:0]  m_word;
    logic         busy;
    logic         timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    aes_stream_adapter dut (
        .AES_clk        (AES_clk),
        .AES_rst        (AES_rst),
        .s_key          (s_key),
        .s_key_load     (s_key_load),
        .s_word_valid   (s_word_valid),
        .s_word_ready   (s_word_ready),
        .s_word         (s_word),
        .core_en        (core_en),
        .core_data      (core_data),
        .core_key       (core_key),
        .core_out_valid (core_out_valid),
        .core_out       (core_out),
        .m_word_valid   (m_word_valid),
        .m_word_ready   (m_word_ready),
        .m_word         (m_word),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 AES_clk = ~AES_clk;

    // Stub core: answers once resp_delay cycles after core_en rises; optional late duplicate.
    int stub_cnt   = 1_000_000;
    int resp_delay = 10;
    bit dup_en     = 1'b0;
    logic en_prev  = 1'b0;

    function automatic logic [127:0] stub_ct(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return d ^ k;
    endfunction

    always @(posedge AES_clk) begin
        en_prev <= core_en;
        if (core_en && !en_prev) stub_cnt <= 1;
        else if (stub_cnt < 1_000_000) stub_cnt <= stub_cnt + 1;
    end

    assign core_out_valid = (stub_cnt == resp_delay) || (dup_en && stub_cnt == resp_delay + 3);
    assign core_out       = (stub_cnt == resp_delay) ? stub_ct(core_data, core_key) : GARBAGE;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        s_key      = k;
        s_key_load = 1'b1;
        @(negedge AES_clk);
        s_key_load = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input bit hold_valid);
        int budget;
        for (int i = 0; i < 4; i++) begin
            s_word       = blk[127-32*i -: 32];
            s_word_valid = 1'b1;
            budget = 0;
            while (!s_word_ready && budget < 300) begin
                @(negedge AES_clk);
                budget++;
            end
            chk("send_ready", s_word_ready, 1'b1);
            @(negedge AES_clk);
        end
        if (!hold_valid) s_word_valid = 1'b0;
    endtask

    task automatic recv_block(input string tag, input logic [127:0] exp, input int stall_idx);
        int budget;
        bit held_ok;
        bit no_overlap;
        logic [31:0] w;
        m_word_ready = 1'b0;
        budget = 0;
        while (!m_word_valid && budget < 300) begin
            @(negedge AES_clk);
            budget++;
        end
        chk({tag, "_valid"}, m_word_valid, 1'b1);
        no_overlap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = exp[127-32*i -: 32];
            if (i == stall_idx) begin
                held_ok = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    if (m_word !== w || m_word_valid !== 1'b1) held_ok = 1'b0;
                    @(negedge AES_clk);
                end
                chk({tag, "_held"}, held_ok, 1'b1);
            end
            if (s_word_ready) no_overlap = 1'b0;
            m_word_ready = 1'b1;
            chk({tag, "_w", $sformatf("%0d", i)}, m_word, w);
            @(negedge AES_clk);
            m_word_ready = 1'b0;
        end
        chk({tag, "_no_input_in_drain"}, no_overlap, 1'b1);
        chk({tag, "_valid_low"}, m_word_valid, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        bit stable_ok;
        bit saw_valid;
        logic [127:0] snap;

        // Reset state
        @(negedge AES_clk);
        @(negedge AES_clk);
        chk("rst_ready", s_word_ready, 1'b0);
        chk("rst_core_en", core_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mvalid", m_word_valid, 1'b0);
        chk("rst_core_data", core_data, 128'h0);
        chk("rst_tmo", timeout_err, 1'b0);
        AES_rst = 1'b0;
        @(negedge AES_clk);
        chk("post_rst_ready", s_word_ready, 1'b1);

        // 1: FIPS-197 vector, duplicate valid pulse must be ignored
        dup_en = 1'b1;
        resp_delay = 10;
        load_key(FIPS_KEY);
        send_block(FIPS_PT, 1'b0);
        recv_block("fips", FIPS_CT, -1);
        dup_en = 1'b0;

        // 2: enable window length and data/key stability
        load_key(128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
        send_block(128'h00000053_00000000_00000000_00000000, 1'b0);
        chk("en_first_cycle", core_en, 1'b1);
        chk("launch_ready", s_word_ready, 1'b0);
        snap = core_data;
        stable_ok = 1'b1;
        n = 0;
        while (core_en && n < 200) begin
            if (core_data !== snap) stable_ok = 1'b0;
            n++;
            @(negedge AES_clk);
        end
        chk("en_cycles", 128'(n), 128'd51);
        chk("data_stable", stable_ok, 1'b1);
        chk("data_value", core_data, 128'h00000053_00000000_00000000_00000000);
        chk("key_value", core_key, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
        recv_block("win", 128'haa2bdb13_bff6a5e8_caa9ba3e_bc1e2acc, -1);

        // 3: backpressure on word 1, result captured during WAIT
        resp_delay = 60;
        load_key(KEY_F);
        send_block(128'h12345678_9abcdef0_0f1e2d3c_4b5a6978, 1'b0);
        recv_block("bp", 128'hedcba987_6543210f_f0e1d2c3_b4a59687, 1);

        // 4: timeout with a silent core
        resp_delay = NEVER;
        send_block(128'h01010101_02020202_03030303_04040404, 1'b0);
        n = 0;
        while (core_en && n < 200) begin
            n++;
            @(negedge AES_clk);
        end
        chk("tmo_en_cycles", 128'(n), 128'd51);
        saw_valid = 1'b0;
        n = 0;
        while (!timeout_err && n < 200) begin
            if (m_word_valid) saw_valid = 1'b1;
            @(negedge AES_clk);
            n++;
        end
        chk("tmo_latency", 128'(n), 128'd64);
        chk("tmo_no_mvalid", saw_valid | m_word_valid, 1'b0);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_ready", s_word_ready, 1'b1);
        @(negedge AES_clk);
        chk("tmo_one_pulse", timeout_err, 1'b0);

        // 5: reset in cycle 20 of the hold, then a fresh block
        resp_delay = 10;
        send_block(128'h0badf00d_0badf00d_0badf00d_0badf00d, 1'b0);
        repeat (19) @(negedge AES_clk);
        chk("midrst_en_before", core_en, 1'b1);
        AES_rst = 1'b1;
        @(negedge AES_clk);
        chk("midrst_core_en", core_en, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", s_word_ready, 1'b0);
        chk("midrst_key", core_key, 128'h0);
        AES_rst = 1'b0;
        @(negedge AES_clk);
        chk("midrst_collect", s_word_ready, 1'b1);
        load_key(KEY_F);
        send_block(128'h01234567_89abcdef_00112233_44556677, 1'b0);
        recv_block("fresh", 128'hfedcba98_76543210_ffeeddcc_bbaa9988, -1);

        // 6: back-to-back, s_word_valid held high, key load outside COLLECT ignored
        send_block(128'h12345678_9abcdef0_0f1e2d3c_4b5a6978, 1'b1);
        s_word = 32'h11111111;
        chk("b2b_ready_launch", s_word_ready, 1'b0);
        load_key(128'h0);
        chk("b2b_key_kept", core_key, KEY_F);
        recv_block("b2b_a", 128'hedcba987_6543210f_f0e1d2c3_b4a59687, -1);
        resp_delay = 60;
        send_block(128'h11111111_22222222_33333333_44444444, 1'b0);
        recv_block("b2b_b", 128'heeeeeeee_dddddddd_cccccccc_bbbbbbbb, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
